i2c_passthru_bus_recovery: RTL

Downstream consumer of the idle/stuck detector's o_stuck. On a stuck bus, it drives the standard I2C recovery sequence on the passthru's bus side: up to 9 SCL clocks until SDA is released, then a STOP condition. It retries a bounded number of times, then reports failure. Its open-drain enables are ORed into the passthru's bus drivers by the parent.

---
 rtl/i2c_passthru_bus_recovery.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/i2c_passthru_bus_recovery.sv
// I2C bus recovery engine: on a stuck bus, clock SCL up to NUM_CLK_PULSES
// times until the slave releases SDA, then issue a STOP. Retries a bounded
// number of attempts before parking in ST_FAIL. Open-drain enables are
// registered from the next state so they never glitch.
module i2c_passthru_bus_recovery #(
  parameter int F_REF_T_LOW       = 38,
  parameter int WIDTH_F_REF_T_LOW = 6,
  parameter int NUM_CLK_PULSES    = 9,
  parameter int WIDTH_CLK_PULSES  = 4,
  parameter int MAX_ATTEMPTS      = 3,
  parameter int WIDTH_ATTEMPTS    = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_f_ref,
  input  logic i_stuck,
  input  logic i_sda,
  input  logic i_scl,
  output logic o_scl_oe,
  output logic o_sda_oe,
  output logic o_busy,
  output logic o_done,
  output logic o_fail
);

  // Handshake-free block: i_stuck/i_en are levels sampled every cycle,
  // o_done is a single-cycle strobe, o_busy/o_fail are levels.

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCL_LOW  = 3'd1,
    ST_SCL_HIGH = 3'd2,
    ST_STOP_A   = 3'd3,
    ST_STOP_B   = 3'd4,
    ST_STOP_C   = 3'd5,
    ST_FAIL     = 3'd6
  } state_t;

  localparam logic [WIDTH_F_REF_T_LOW-1:0] TIMER_LOAD = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
  localparam logic [WIDTH_CLK_PULSES-1:0]  PULSE_MAX  = WIDTH_CLK_PULSES'(NUM_CLK_PULSES);
  localparam logic [WIDTH_ATTEMPTS-1:0]    ATTEMPT_MAX = WIDTH_ATTEMPTS'(MAX_ATTEMPTS);

  state_t                         state_q, state_d;
  logic [WIDTH_F_REF_T_LOW-1:0]   timer_q, timer_d;
  logic [WIDTH_CLK_PULSES-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic [WIDTH_ATTEMPTS-1:0]      attempts_q, attempts_d;
  logic                           prev_f_ref_q;
  logic                           scl_oe_q, scl_oe_d;
  logic                           sda_oe_q, sda_oe_d;
  logic                           done_q, done_d;

  logic                           f_pulse;
  logic                           tc;
  logic                           count_en;
  logic [WIDTH_CLK_PULSES-1:0]    pulse_inc;
  logic [WIDTH_ATTEMPTS-1:0]      attempts_inc;

  // Reference tick edge detect, terminal count and phase-timer gating.
  always_comb begin
    f_pulse      = ~prev_f_ref_q & i_f_ref;
    tc           = (timer_q == '0);
    // Released-SCL phases honour clock stretching: time only runs while SCL is high.
    count_en     = ((state_q == ST_SCL_HIGH) || (state_q == ST_STOP_B)) ? i_scl : 1'b1;
    pulse_inc    = (pulse_cnt_q >= PULSE_MAX) ? PULSE_MAX : pulse_cnt_q + 1'b1;
    attempts_inc = attempts_q + 1'b1;
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    attempts_d  = attempts_q;
    done_d      = 1'b0;
    timer_d     = timer_q;
    scl_oe_d    = 1'b0;
    sda_oe_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_stuck) begin
          pulse_cnt_d = '0;
          attempts_d  = '0;
          state_d     = ST_SCL_LOW;
        end
      end
      ST_SCL_LOW: begin
        if (tc) state_d = ST_SCL_HIGH;
      end
      ST_SCL_HIGH: begin
        if (tc) begin
          pulse_cnt_d = pulse_inc;
          if (i_sda) begin
            state_d = ST_STOP_A;
          end else if (pulse_inc < PULSE_MAX) begin
            state_d = ST_SCL_LOW;
          end else if (attempts_inc < ATTEMPT_MAX) begin
            attempts_d  = attempts_inc;
            pulse_cnt_d = '0;
            state_d     = ST_SCL_LOW;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_STOP_A: begin
        if (tc) state_d = ST_STOP_B;
      end
      ST_STOP_B: begin
        if (tc) state_d = ST_STOP_C;
      end
      ST_STOP_C: begin
        if (tc) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: begin
        if (!i_stuck) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins over everything, including a completing STOP.
    if (!i_en) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end

    // Timer reloads on every state change, otherwise counts down to zero.
    if (state_d != state_q) begin
      timer_d = TIMER_LOAD;
    end else if (f_pulse && count_en && !tc) begin
      timer_d = timer_q - 1'b1;
    end

    scl_oe_d = (state_d == ST_SCL_LOW) || (state_d == ST_STOP_A);
    sda_oe_d = (state_d == ST_STOP_A)  || (state_d == ST_STOP_B);
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= TIMER_LOAD;
      pulse_cnt_q  <= '0;
      attempts_q   <= '0;
      prev_f_ref_q <= 1'b0;
      scl_oe_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pulse_cnt_q  <= pulse_cnt_d;
      attempts_q   <= attempts_d;
      prev_f_ref_q <= i_f_ref;
      scl_oe_q     <= scl_oe_d;
      sda_oe_q     <= sda_oe_d;
      done_q       <= done_d;
    end
  end

  // Status outputs follow the current state.
  always_comb begin
    o_scl_oe = scl_oe_q;
    o_sda_oe = sda_oe_q;
    o_done   = done_q;
    o_busy   = (state_q != ST_IDLE) && (state_q != ST_FAIL);
    o_fail   = (state_q == ST_FAIL);
  end

endmodule
